// File: rtl/gelato_warp_fetch.sv
// Per-warp fetch stage: parks the selected split entry, fetches its instruction, hands it to decode.
// Defining GELATO_FETCH_TIMEOUT_EN adds a memory-wait timeout that reissues the same request.
module gelato_warp_fetch #(
    parameter int PC_WIDTH        = 32,
    parameter int INST_WIDTH      = 32,
    parameter int SPLIT_NUM_WIDTH = 2,
    parameter int THREAD_NUM      = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rdy,
    input  logic                       sel_valid,
    input  logic [PC_WIDTH-1:0]        sel_pc,
    input  logic [SPLIT_NUM_WIDTH-1:0] sel_split_table_num,
    output logic                       upd_valid,
    output logic [SPLIT_NUM_WIDTH-1:0] upd_split_table_num,
    output logic [PC_WIDTH-1:0]        upd_pc,
    output logic                       upd_stall,
    input  logic [THREAD_NUM-1:0]      upd_thread_mask,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [PC_WIDTH-1:0]        imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [INST_WIDTH-1:0]      imem_resp_inst,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [PC_WIDTH-1:0]        dec_pc,
    output logic [INST_WIDTH-1:0]      dec_inst,
    output logic [SPLIT_NUM_WIDTH-1:0] dec_split_table_num,
    output logic [THREAD_NUM-1:0]      dec_thread_mask,
    output logic                       busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_OUT} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [SPLIT_NUM_WIDTH-1:0] r_num;
    logic [INST_WIDTH-1:0]      r_inst;
    logic [THREAD_NUM-1:0]      r_mask;
    logic                       r_upd_valid;
    logic                       r_upd_stall;
    logic [PC_WIDTH-1:0]        r_upd_pc;
    logic                       w_take_sel;
    logic                       w_take_inst;
    logic                       w_accept;
    logic                       w_first_req;
    logic                       w_timeout;

`ifdef GELATO_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Counts WAIT cycles; any other state leaves it at zero so each WAIT entry starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (rdy) begin
            if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            else                    r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_timeout        = 1'b0;
`endif

    // The stall pulse is the only upd_valid seen in REQ, so it marks the first REQ cycle.
    assign w_first_req = (r_state == ST_REQ) && r_upd_valid && r_upd_stall;

    always_comb begin
        w_state_nxt = r_state;
        w_take_sel  = 1'b0;
        w_take_inst = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            // Waiting out a reactivate pulse keeps upd_valid from firing on back-to-back cycles.
            ST_IDLE: begin
                if (sel_valid && !r_upd_valid) begin
                    w_take_sel  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    w_take_inst = 1'b1;
                    w_state_nxt = ST_OUT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_OUT: begin
                if (dec_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_num       <= '0;
            r_inst      <= '0;
            r_mask      <= '0;
            r_upd_valid <= 1'b0;
            r_upd_stall <= 1'b0;
            r_upd_pc    <= '0;
        end else if (rdy) begin
            r_state     <= w_state_nxt;
            r_upd_valid <= w_take_sel | w_accept;
            r_upd_stall <= w_take_sel;
            if (w_take_sel) begin
                r_pc     <= sel_pc;
                r_num    <= sel_split_table_num;
                r_upd_pc <= sel_pc;
            end
            if (w_accept)    r_upd_pc <= r_pc + PC_WIDTH'(4);
            if (w_first_req) r_mask   <= upd_thread_mask;
            if (w_take_inst) r_inst   <= imem_resp_inst;
        end
    end

    assign upd_valid           = r_upd_valid;
    assign upd_stall           = r_upd_stall;
    assign upd_pc              = r_upd_pc;
    assign upd_split_table_num = r_num;
    assign imem_req_valid      = (r_state == ST_REQ);
    assign imem_req_addr       = r_pc;
    assign dec_valid           = (r_state == ST_OUT);
    assign dec_pc              = r_pc;
    assign dec_inst            = r_inst;
    assign dec_split_table_num = r_num;
    assign dec_thread_mask     = r_mask;
    assign busy                = (r_state != ST_IDLE);
endmodule
